// File: rtl/i2s_stream_pkg.sv
// ---------------------------------------------------------------------------
// i2s_stream_pkg : shared state encoding and default constants for the I2S
//                  stream controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2s_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int DEFAULT_SAMPLE_W   = 24;
  localparam int DEFAULT_CONF_RES   = 24;
  localparam int DEFAULT_CONF_RATIO = 4;

endpackage

`default_nettype wire

// File: rtl/i2s_stream_fifo.sv
// ---------------------------------------------------------------------------
// i2s_stream_fifo : synchronous FIFO with flush. It holds filtered samples
//                   until the TX codec requests them.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2s_stream_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_dat;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2s_stream_ctrl.sv
// ---------------------------------------------------------------------------
// i2s_stream_ctrl : sequences the I2S RX/TX codec pair and streams samples
//                   between them and the audio filter.
// Optional feature: I2S_STREAM_CTRL_STATS_EN adds saturating over/underrun counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2s_stream_ctrl
  import i2s_stream_pkg::*;
#(
  parameter int SAMPLE_W       = DEFAULT_SAMPLE_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARTUP_CYCLES = 1024,
  parameter int CONF_RES       = DEFAULT_CONF_RES,
  parameter int CONF_RATIO     = DEFAULT_CONF_RATIO
) (
  input  logic                lmmi_clk_i,
  input  logic                reset_n_i,
  input  logic                run_i,
  output logic                conf_en_o,
  output logic [5:0]          conf_res_o,
  output logic [9:0]          conf_ratio_o,
  input  logic [31:0]         rx_dat_i,
  input  logic                rx_rdwr_i,
  output logic [31:0]         tx_dat_o,
  input  logic                tx_rdwr_i,
  output logic [SAMPLE_W-1:0] proc_dat_o,
  output logic                proc_ch_o,
  output logic                proc_valid_o,
  input  logic                proc_ready_i,
  input  logic [SAMPLE_W-1:0] res_dat_i,
  input  logic                res_valid_i,
  output logic                res_ready_o,
  output logic [1:0]          state_o,
  output logic                overrun_o,
  output logic                underrun_o
`ifdef I2S_STREAM_CTRL_STATS_EN
  ,
  output logic [15:0]         overrun_cnt_o,
  output logic [15:0]         underrun_cnt_o
`endif
);

  localparam int CNT_W = $clog2(STARTUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                conf_en_q, conf_en_d;
  logic                ch_q, ch_d;
  logic [SAMPLE_W-1:0] proc_dat_q, proc_dat_d;
  logic                proc_ch_q, proc_ch_d;
  logic                proc_valid_q, proc_valid_d;
  logic                overrun_q, overrun_d;
  logic                underrun_q, underrun_d;

  logic                fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                run_st;

  assign run_st = (state_q == ST_RUN);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    conf_en_d    = (state_q != ST_IDLE);
    proc_dat_d   = proc_dat_q;
    proc_ch_d    = proc_ch_q;
    proc_valid_d = proc_valid_q;
    overrun_d    = 1'b0;
    underrun_d   = 1'b0;

    if (conf_en_q && rx_rdwr_i) begin
      ch_d = ~ch_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (run_i) begin
          state_d = ST_WARMUP;
          cnt_d   = '0;
          ch_d    = 1'b0;
        end
      end
      ST_WARMUP: begin
        if (!run_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!run_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (run_st) begin
      if (proc_valid_q && proc_ready_i) begin
        proc_valid_d = 1'b0;
      end
      // A new word only lands if the held one is gone or leaving this cycle.
      if (rx_rdwr_i) begin
        if (!proc_valid_q || proc_ready_i) begin
          proc_dat_d   = rx_dat_i[SAMPLE_W-1:0];
          proc_ch_d    = ch_q;
          proc_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      underrun_d = tx_rdwr_i && fifo_empty;
    end

    if (state_d == ST_IDLE) begin
      proc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      conf_en_q    <= 1'b0;
      ch_q         <= 1'b0;
      proc_dat_q   <= '0;
      proc_ch_q    <= 1'b0;
      proc_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      conf_en_q    <= conf_en_d;
      ch_q         <= ch_d;
      proc_dat_q   <= proc_dat_d;
      proc_ch_q    <= proc_ch_d;
      proc_valid_q <= proc_valid_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  // Holding flush through IDLE also empties the FIFO on the way into WARMUP.
  assign fifo_flush  = (state_q == ST_IDLE) || (state_d == ST_IDLE);
  assign res_ready_o = !fifo_full && (state_q != ST_IDLE);
  assign fifo_push   = res_valid_i && res_ready_o;
  assign fifo_pop    = tx_rdwr_i && run_st;

  i2s_stream_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (lmmi_clk_i),
    .rst_n    (reset_n_i),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_dat (res_dat_i),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign tx_dat_o = (run_st && !fifo_empty) ?
                    {{(32-SAMPLE_W){fifo_head[SAMPLE_W-1]}}, fifo_head} : 32'h0;

  assign conf_en_o    = conf_en_q;
  assign conf_res_o   = 6'(CONF_RES);
  assign conf_ratio_o = 10'(CONF_RATIO);
  assign proc_dat_o   = proc_dat_q;
  assign proc_ch_o    = proc_ch_q;
  assign proc_valid_o = proc_valid_q;
  assign state_o      = state_q;
  assign overrun_o    = overrun_q;
  assign underrun_o   = underrun_q;

`ifdef I2S_STREAM_CTRL_STATS_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;
  logic [15:0] und_cnt_q, und_cnt_d;
  logic        stats_clr;

  assign stats_clr = (state_q == ST_IDLE) && (state_d == ST_WARMUP);

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    und_cnt_d = und_cnt_q;
    if (stats_clr) begin
      ovr_cnt_d = '0;
      und_cnt_d = '0;
    end else begin
      if (overrun_q && (ovr_cnt_q != 16'hFFFF)) ovr_cnt_d = ovr_cnt_q + 16'd1;
      if (underrun_q && (und_cnt_q != 16'hFFFF)) und_cnt_d = und_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovr_cnt_q <= '0;
      und_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
      und_cnt_q <= und_cnt_d;
    end
  end

  assign overrun_cnt_o  = ovr_cnt_q;
  assign underrun_cnt_o = und_cnt_q;
`endif

endmodule

`default_nettype wire
